// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the sync polarity helper used by
// the VGA timing generator.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int   DEF_CW       = 10;
  localparam logic DEF_SYNC_POL = 1'b0;

  // Drive level of a sync line: pol while the pulse is active, ~pol otherwise.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with next-state decode of the
// active-video and sync windows.
module vga_axis_counter #(
  parameter int TOTAL  = 800,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] cnt_next,
  output logic          wrap,
  output logic          in_active,
  output logic          in_sync
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] cnt_reg;

  // Reset parks on the last position so the first enable lands on zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= LAST;
    else        cnt_reg <= cnt_next;
  end

  assign wrap = (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (en) cnt_next = wrap ? '0 : cnt_reg + CW'(1);
  end

  assign in_active = int'(cnt_next) < ACTIVE;
  assign in_sync   = (int'(cnt_next) >= ACTIVE + FP) && (int'(cnt_next) < ACTIVE + FP + SYNC);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: advances on pix_en and presents registered
// coordinates, sync levels, blanking flag and line/frame start pulses.
module vga_sync_gen #(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = vga_timing_pkg::DEF_SYNC_POL,
  parameter int   CW       = vga_timing_pkg::DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_cw_too_small
    $error("vga_sync_gen: CW too narrow for the raster totals");
  end

  logic [CW-1:0] h_next, v_next;
  logic          h_wrap, v_wrap, h_act, v_act, h_syn, v_syn;
  logic          v_en;

  // The line counter steps only on the strobe that wraps x back to 0.
  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .CW(CW)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .en(pix_en),
    .cnt_next(h_next), .wrap(h_wrap), .in_active(h_act), .in_sync(h_syn)
  );

  vga_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .CW(CW)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .en(v_en),
    .cnt_next(v_next), .wrap(v_wrap), .in_active(v_act), .in_sync(v_syn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= CW'(H_TOTAL - 1);
      y           <= CW'(V_TOTAL - 1);
      hsync       <= sync_level(1'b0, SYNC_POL);
      vsync       <= sync_level(1'b0, SYNC_POL);
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= h_next;
      y           <= v_next;
      hsync       <= sync_level(h_syn, SYNC_POL);
      vsync       <= sync_level(v_syn, SYNC_POL);
      video_on    <= h_act & v_act;
      line_start  <= v_en;
      frame_start <= v_en & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomised bench for vga_sync_gen: full-size 640x480 instance plus two
// shrunken rasters (both sync polarities) so whole frames fit in the run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  // Full 640x480 instance
  logic s_hs, s_vs, s_vo, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  // Small 32x20 raster, active-low (a) and active-high (b) syncs
  logic a_hs, a_vs, a_vo, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic b_hs, b_vs, b_vo, b_ls, b_fs;
  logic [9:0] b_x, b_y;

  vga_sync_gen dut_std (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b0), .CW(10)
  ) dut_sm_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_POL(1'b1), .CW(10)
  ) dut_sm_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: linear pixel index within the frame; x/y derived by div/mod.
  localparam int STD_W = 800, STD_FRAME = 800 * 525;
  localparam int SM_W  = 32,  SM_FRAME  = 32 * 20;

  int unsigned p_std = STD_FRAME - 1;
  int unsigned p_sm  = SM_FRAME - 1;
  logic        stb_d = 1'b0;
  int          frames_model = 0;
  int          frames_seen  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_std <= STD_FRAME - 1;
      p_sm  <= SM_FRAME - 1;
      stb_d <= 1'b0;
    end else begin
      stb_d <= pix_en;
      if (pix_en) begin
        p_std <= (p_std + 1) % STD_FRAME;
        p_sm  <= (p_sm + 1) % SM_FRAME;
        if ((p_sm + 1) % SM_FRAME == 0) frames_model <= frames_model + 1;
      end
    end
  end

  always @(negedge clk) if (a_fs) frames_seen <= frames_seen + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      int ex, ey;
      ex = int'(p_std % STD_W);
      ey = int'(p_std / STD_W);
      check_eq("std_x", s_x, ex);
      check_eq("std_y", s_y, ey);
      check_eq("std_video_on", s_vo, (ex < 640 && ey < 480));
      check_eq("std_hsync", s_hs, !(ex >= 656 && ex < 752));
      check_eq("std_vsync", s_vs, !(ey >= 490 && ey < 492));
      check_eq("std_line_start", s_ls, stb_d && ex == 0);
      check_eq("std_frame_start", s_fs, stb_d && p_std == 0);
      ex = int'(p_sm % SM_W);
      ey = int'(p_sm / SM_W);
      check_eq("sm_x", a_x, ex);
      check_eq("sm_y", a_y, ey);
      check_eq("sm_video_on", a_vo, (ex < 16 && ey < 12));
      check_eq("sm_hsync_lo", a_hs, !(ex >= 20 && ex < 26));
      check_eq("sm_vsync_lo", a_vs, !(ey >= 14 && ey < 16));
      check_eq("sm_hsync_hi", b_hs, (ex >= 20 && ex < 26));
      check_eq("sm_vsync_hi", b_vs, (ey >= 14 && ey < 16));
      check_eq("sm_line_start", a_ls, stb_d && ex == 0);
      check_eq("sm_frame_start", a_fs, stb_d && p_sm == 0);
      check_eq("smp_xy", {b_x, b_y, b_vo, b_ls, b_fs}, {a_x, a_y, a_vo, a_ls, a_fs});
    end
  end

  initial begin
    int guard;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    $display("tb: reset held, releasing");
    rst_n = 1'b1;
    @(negedge clk);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check_eq("first_x", s_x, 0);
    check_eq("first_frame_start", s_fs, 1);
    @(negedge clk);
    check_eq("first_ls_width", s_ls, 0);
    $display("tb: first strobe landed at (%0d,%0d)", s_x, s_y);

    for (int i = 0; i < 2400 * 4; i++) begin
      pix_en = (i % 4 == 3);
      @(negedge clk);
    end
    pix_en = 1'b0;
    $display("tb: quarter-rate strobes done at (%0d,%0d)", s_x, s_y);

    guard = 0;
    while ((p_std % STD_W) != 300 && guard < 2000) begin
      pix_en = 1'b1;
      @(negedge clk);
      guard++;
    end
    pix_en = 1'b0;
    check_eq("reach_x300", (guard < 2000), 1);
    repeat (100) @(negedge clk);
    check_eq("hold_x", s_x, 300);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check_eq("resume_x", s_x, 301);
    $display("tb: hold of 100 clks at x=300 done");

    pix_en = 1'b1;
    repeat (3000) @(negedge clk);
    $display("tb: continuous strobes done at (%0d,%0d)", s_x, s_y);

    repeat (4000) begin
      pix_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    pix_en = 1'b0;
    $display("tb: random strobes done at (%0d,%0d)", s_x, s_y);

    #2 rst_n = 1'b0;
    #1;
    check_eq("async_x", s_x, 799);
    check_eq("async_y", s_y, 524);
    check_eq("async_hsync", s_hs, 1);
    check_eq("async_vsync", s_vs, 1);
    check_eq("async_video_on", s_vo, 0);
    check_eq("async_sm_x", a_x, 31);
    check_eq("async_hi_hsync", b_hs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check_eq("restart_xy", {s_x, s_y}, 20'd0);
    check_eq("restart_frame_start", s_fs, 1);
    $display("tb: mid-frame reset and restart done");

    repeat (3000) begin
      pix_en = ($urandom_range(0, 1) != 0);
      @(negedge clk);
    end
    pix_en = 1'b0;
    @(negedge clk);
    check_eq("frame_count", frames_seen, frames_model);
    $display("tb: %0d small frames observed", frames_seen);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
